sop_eval_pipe: RTL and testbench
================================

// Module: sop_eval_pipe
// PURPOSE
//  Parametrised, pipelined sum-of-products evaluator: z = OR over i of (a[i] & c[i]).
//  With WIDTH=2, a={B,A} and c={D,C} it computes Z = AC + BD.
//  Generalised to WIDTH terms and four reduction modes, with valid/ready flow
//  control, a synchronous flush and an optional saturating hit counter.
//  Sits between logic-vector producers and consumers in the gate-level exercise datapath.
// PARAMETERS
//  WIDTH  2  number of product terms (lanes), >=1
//  CNT_W  8  width of hit_cnt (only used when SOP_HITCNT_EN is defined), >=1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active-low
//  flush      in   1      synchronous flush; drops all in-flight results
//  in_valid   in   1      input vector valid
//  in_ready   out  1      block can accept input this cycle
//  a          in   WIDTH  first operand of each term
//  c          in   WIDTH  second operand of each term
//  mode       in   2      00 SOP |(a&c); 01 POS &(a|c); 10 XSOP ^(a&c); 11 NSOP ~|(a&c)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  z          out  1      reduced result
//  term_vec   out  WIDTH  per-lane terms: a&c (modes 00/10/11) or a|c (mode 01)
//  hit_cnt    out  CNT_W  count of accepted results with z=1 (SOP_HITCNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): s1_valid=s2_valid=0; out_valid=0, z=0, term_vec=0, hit_cnt=0.
//  - Stage S1: on an input transfer (in_valid & in_ready), register the per-lane term
//    vector (chosen by mode) and mode. Set s1_valid.
//  - Stage S2: when S1 advances, apply the mode reduction to the S1 term vector.
//    Register z and term_vec. Set s2_valid.
//  - Advance rules:
//    s2_free  = ~s2_valid | out_ready.
//    s1_free  = ~s1_valid | s2_free.
//    in_ready = ~flush & s1_free. This path is combinational from out_ready.
//  - out_valid = s2_valid & ~flush. Transfer occurs when out_valid & out_ready.
//  - Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
//    Throughput is 1 result per cycle; no bubbles under continuous ready.
//  - Backpressure: while out_valid & ~out_ready, z and term_vec hold stable.
//    S1 fills, then in_ready=0. At most 2 results are in flight; none are lost or duplicated.
//  - Flush: during the flush cycle no input or output transfer occurs.
//    On the next edge s1_valid=s2_valid=0. z and term_vec keep their last value (don't-care).
//    Flush overrides simultaneous in_valid and out_ready.
//  - mode is sampled with its operands. Changing mode mid-stream affects only later inputs.
//  - WIDTH=1: SOP = a&c, POS = a|c, XSOP = a&c, NSOP = ~(a&c).
//  - Reset mid-operation clears both stages immediately. The first result after release
//    comes from the first input accepted after release.
// CONFIGURATION
//  - Macro SOP_HITCNT_EN.
//  - Defined: hit_cnt increments by 1 on each output transfer with z=1.
//    It saturates at 2^CNT_W-1 (no wrap) and is cleared by reset or flush.
//    A flush cycle never counts.
//  - Not defined: the hit_cnt port still exists, is tied to 0, and no counter register
//    is built.
// TESTING  (WIDTH=2; A=a[0], B=a[1], C=c[0], D=c[1]; out_ready=1 unless stated)
//  1. SOP sweep: mode=00; (A,B,C,D) = 0000, 0100, 1011, 1111 on consecutive cycles.
//     Expect z = 0, 0, 1, 1, each 2 cycles after its input.
//     Expect term_vec = 00, 00, 01, 11.
//  2. Modes: a=01, c=10. mode=01 -> z=1. mode=00 -> z=0. mode=10 -> z=0. mode=11 -> z=1.
//     Then a=11, c=11, mode=10 -> z=0.
//  3. Backpressure: out_ready=0, push 3 inputs. Expect 2 accepted, then in_ready=0.
//     z is held. Raise out_ready: results emerge in order, the 3rd input is accepted,
//     and no loss or duplication occurs.
//  4. Flush: 2 results in flight, out_ready=0; pulse flush with in_valid=1.
//     Expect out_valid=0 and in_ready=0 that cycle, both stages empty next cycle,
//     and the held input not accepted.
//  5. Reset: assert rst_n=0 asynchronously mid-stream. out_valid drops without waiting
//     for a clock edge. After release, out_valid stays 0 until 2 cycles after the
//     next accepted input.
//  6. SOP_HITCNT_EN, CNT_W=2: 5 accepted z=1 results -> hit_cnt=3 (saturated).
//     A z=0 result does not change it. Flush -> hit_cnt=0.

Source files
------------

// File: rtl/sop_eval_pipe.sv
// Two-stage pipelined sum-of-products evaluator with four reduction modes and valid/ready flow control.
// Optional saturating hit counter is built only when SOP_HITCNT_EN is defined.
module sop_eval_pipe #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z,
    output logic [WIDTH-1:0] term_vec,
    output logic [CNT_W-1:0] hit_cnt
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and in_ready is combinational from out_ready and flush.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_term;
    logic [1:0]       s1_mode;
    logic             s2_valid;
    logic             s2_free;
    logic             s1_free;
    logic [WIDTH-1:0] in_term;
    logic             z_next;

    assign s2_free   = ~s2_valid | out_ready;
    assign s1_free   = ~s1_valid | s2_free;
    assign in_ready  = ~flush & s1_free;
    assign out_valid = s2_valid & ~flush;

    // POS works on OR terms; every other mode reduces AND terms.
    assign in_term = (mode == 2'b01) ? (a | c) : (a & c);

    always_comb begin
        z_next = 1'b0;
        case (s1_mode)
            2'b00:   z_next = |s1_term;
            2'b01:   z_next = &s1_term;
            2'b10:   z_next = ^s1_term;
            default: z_next = ~|s1_term;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_term  <= '0;
            s1_mode  <= 2'b00;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_term <= in_term;
                s1_mode <= mode;
            end
        end
    end

    // S2 holds z and term_vec stable whenever the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            z        <= 1'b0;
            term_vec <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                z        <= z_next;
                term_vec <= s1_term;
            end
        end
    end

`ifdef SOP_HITCNT_EN
    // Counts output transfers carrying z=1; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (flush) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && z && (hit_cnt != {CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Bench for sop_eval_pipe: directed scenarios plus randomized traffic against a queue-based reference.
// hit_cnt expectations follow the SOP_HITCNT_EN build setting.
module tb_sop_eval_pipe;
    localparam int WIDTH = 2;
    localparam int CNT_W = 2;
    localparam int W     = WIDTH + 1;
`ifdef SOP_HITCNT_EN
    localparam int HIT_SAT_EXP = 3;
`else
    localparam int HIT_SAT_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] c = '0;
    logic [1:0]       mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             z;
    logic [WIDTH-1:0] term_vec;
    logic [CNT_W-1:0] hit_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_hit = 0;
    logic [W-1:0] exp_q[$];
    int age_q[$];

    sop_eval_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .c(c), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .term_vec(term_vec), .hit_cnt(hit_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    // reference: terms and reduction derived from counting set bits
    function automatic logic [W-1:0] ref_model(logic [WIDTH-1:0] av, logic [WIDTH-1:0] cv, logic [1:0] m);
        logic [WIDTH-1:0] t;
        int ones;
        logic r;
        t = (m == 2'b01) ? (av | cv) : (av & cv);
        ones = $countones(t);
        case (m)
            2'b00:   r = (ones != 0);
            2'b01:   r = (ones == WIDTH);
            2'b10:   r = ones[0];
            default: r = (ones == 0);
        endcase
        return {r, t};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic v, logic [WIDTH-1:0] av, logic [WIDTH-1:0] cv, logic [1:0] m);
        in_valid = v;
        a = av;
        c = cv;
        mode = m;
    endtask

    // scoreboard step: called just after a falling edge with inputs already driven
    task automatic tick(output logic accepted);
        logic exp_rdy;
        logic exp_ov;
        logic [W-1:0] front;
        int hit_now;
        #1;
        exp_rdy = !flush && (exp_q.size() < 2 || out_ready);
        exp_ov  = !flush && (exp_q.size() > 0) && ((cyc - age_q[0]) >= 2);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
`ifdef SOP_HITCNT_EN
        hit_now = exp_hit;
`else
        hit_now = 0;
`endif
        chk("hit_cnt", 32'(hit_cnt), 32'(hit_now));
        if (exp_ov) begin
            front = exp_q[0];
            chk("z", 32'(z), 32'(front[WIDTH]));
            chk("term_vec", 32'(term_vec), 32'(front[WIDTH-1:0]));
            if (out_ready) begin
                void'(exp_q.pop_front());
                void'(age_q.pop_front());
                if (front[WIDTH] && exp_hit < (1 << CNT_W) - 1) exp_hit++;
            end
        end
        accepted = in_valid && exp_rdy;
        if (accepted) begin
            exp_q.push_back(ref_model(a, c, mode));
            age_q.push_back(cyc);
        end
        if (flush) begin
            exp_q.delete();
            age_q.delete();
            exp_hit = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        logic acc;
        set_in(1'b0, '0, '0, 2'b00);
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send_and_check(string tag, logic [WIDTH-1:0] av, logic [WIDTH-1:0] cv,
                                  logic [1:0] m, logic exp_z);
        logic acc;
        set_in(1'b1, av, cv, m);
        tick(acc);
        set_in(1'b0, '0, '0, 2'b00);
        tick(acc);
        #1;
        chk(tag, 32'(z), 32'(exp_z));
        tick(acc);
    endtask

    initial begin
        logic acc;
        // reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_term_vec", 32'(term_vec), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // SOP sweep on consecutive cycles: (A,B,C,D)=0000,0100,1011,1111
        set_in(1'b1, 2'b00, 2'b00, 2'b00); tick(acc);
        set_in(1'b1, 2'b10, 2'b00, 2'b00); tick(acc);
        set_in(1'b1, 2'b01, 2'b11, 2'b00); tick(acc);
        set_in(1'b1, 2'b11, 2'b11, 2'b00); tick(acc);
        idle(3);

        // modes with fixed-constant expectations
        send_and_check("mode_pos",  2'b01, 2'b10, 2'b01, 1'b1);
        send_and_check("mode_sop",  2'b01, 2'b10, 2'b00, 1'b0);
        send_and_check("mode_xsop", 2'b01, 2'b10, 2'b10, 1'b0);
        send_and_check("mode_nsop", 2'b01, 2'b10, 2'b11, 1'b1);
        send_and_check("xsop_even", 2'b11, 2'b11, 2'b10, 1'b0);

        // backpressure: third input stalls until the consumer drains
        out_ready = 1'b0;
        set_in(1'b1, 2'b11, 2'b01, 2'b00); tick(acc);
        set_in(1'b1, 2'b10, 2'b11, 2'b11); tick(acc);
        set_in(1'b1, 2'b11, 2'b11, 2'b01);
        for (int i = 0; i < 3; i++) tick(acc);
        chk("bp_stalled_count", 32'(exp_q.size()), 2);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) tick(acc);
        chk("bp_third_accepted", 32'(acc), 1);
        idle(3);

        // flush with two in flight and a held input
        out_ready = 1'b0;
        set_in(1'b1, 2'b01, 2'b01, 2'b00); tick(acc);
        set_in(1'b1, 2'b10, 2'b10, 2'b00); tick(acc);
        set_in(1'b1, 2'b11, 2'b11, 2'b00);
        flush = 1'b1; out_ready = 1'b1;
        tick(acc);
        flush = 1'b0;
        idle(3);

        // asynchronous reset mid-stream
        set_in(1'b1, 2'b11, 2'b10, 2'b00); tick(acc);
        set_in(1'b1, 2'b01, 2'b11, 2'b10); tick(acc);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        exp_q.delete();
        age_q.delete();
        exp_hit = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        set_in(1'b1, 2'b10, 2'b10, 2'b00); tick(acc);
        idle(3);

        // hit counter saturation, z=0 result, then flush clears
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'b11, 2'b11, 2'b00); tick(acc);
        end
        set_in(1'b1, 2'b00, 2'b11, 2'b00); tick(acc);
        idle(3);
        #1;
        chk("hit_saturated", 32'(hit_cnt), HIT_SAT_EXP);
        flush = 1'b1; tick(acc); flush = 1'b0;
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            tick(acc);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
